// File: rtl/branch_predictor.sv
// Branch target buffer with 2-bit saturating direction counters.
// Lookup side predicts the next fetch PC. Resolve side flags mispredicts and
// jumps for the hazard unit, produces the redirect PC and keeps branch statistics.
module branch_predictor #(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        res_valid,
  input  logic        res_en,
  input  logic [31:0] res_pc,
  input  logic        res_is_branch,
  input  logic        res_is_jump,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  input  logic [31:0] res_npc,
  input  logic        res_pred_taken,
  input  logic [31:0] res_pred_target,
  output logic        mispredict,
  output logic        jumping,
  output logic [31:0] correct_pc,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int unsigned IDX_W   = $clog2(ENTRIES);
  localparam int unsigned TAG_W   = 32 - IDX_W - 2;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Table storage, one array per entry field
  logic             tbl_valid  [ENTRIES];
  logic [TAG_W-1:0] tbl_tag    [ENTRIES];
  logic [31:0]      tbl_target [ENTRIES];
  logic [1:0]       tbl_ctr    [ENTRIES];

  logic [IDX_W-1:0] look_idx;
  logic [TAG_W-1:0] look_tag;
  logic             look_hit;

  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             upd_fire;

  // Word-offset bits of the PCs carry no BTB information
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc[1:0], res_pc[1:0]};

  // Lookup: combinational read of registered table state, no bypass
  assign look_idx    = pc[IDX_W+1:2];
  assign look_tag    = pc[31:IDX_W+2];
  assign look_hit    = tbl_valid[look_idx] && (tbl_tag[look_idx] == look_tag);
  assign pred_taken  = look_hit && tbl_ctr[look_idx][1];
  assign pred_target = pred_taken ? tbl_target[look_idx] : 32'h0;

  // Resolve: hazard-unit controls and redirect PC, independent of res_en
  assign mispredict = res_valid && res_is_branch &&
                      ((res_taken != res_pred_taken) ||
                       (res_taken && (res_target != res_pred_target)));
  assign jumping    = res_valid && res_is_jump;
  assign correct_pc = (res_is_jump || res_taken) ? res_target : res_npc;

  assign upd_idx  = res_pc[IDX_W+1:2];
  assign upd_tag  = res_pc[31:IDX_W+2];
  assign upd_hit  = tbl_valid[upd_idx] && (tbl_tag[upd_idx] == upd_tag);
  assign upd_fire = res_valid && res_en && res_is_branch;

  // Table update: train on hit, allocate on taken miss, ignore not-taken miss
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tbl_valid[i]  <= 1'b0;
        tbl_tag[i]    <= '0;
        tbl_target[i] <= 32'h0;
        tbl_ctr[i]    <= 2'b01;
      end
    end else if (upd_fire) begin
      if (upd_hit) begin
        if (res_taken) begin
          tbl_ctr[upd_idx]    <= (tbl_ctr[upd_idx] == 2'b11) ? 2'b11 : tbl_ctr[upd_idx] + 2'd1;
          tbl_target[upd_idx] <= res_target;
        end else begin
          tbl_ctr[upd_idx]    <= (tbl_ctr[upd_idx] == 2'b00) ? 2'b00 : tbl_ctr[upd_idx] - 2'd1;
        end
      end else if (res_taken) begin
        tbl_valid[upd_idx]  <= 1'b1;
        tbl_tag[upd_idx]    <= upd_tag;
        tbl_target[upd_idx] <= res_target;
        tbl_ctr[upd_idx]    <= 2'b10;
      end
    end
  end

  // Statistics: saturating counts of resolved branches and mispredicts
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      branch_count     <= 32'h0;
      mispredict_count <= 32'h0;
    end else if (upd_fire) begin
      if (branch_count != CNT_MAX) begin
        branch_count <= branch_count + 32'd1;
      end
      if (mispredict && (mispredict_count != CNT_MAX)) begin
        mispredict_count <= mispredict_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: combinational resolve vectors,
// directed multi-cycle sequences and randomized traffic against a reference model.
module tb_branch_predictor;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned IDX_W   = 4;

  logic        CLK;
  logic        nRST;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        res_valid;
  logic        res_en;
  logic [31:0] res_pc;
  logic        res_is_branch;
  logic        res_is_jump;
  logic        res_taken;
  logic [31:0] res_target;
  logic [31:0] res_npc;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic        mispredict;
  logic        jumping;
  logic [31:0] correct_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .CLK(CLK), .nRST(nRST), .pc(pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_en(res_en), .res_pc(res_pc),
    .res_is_branch(res_is_branch), .res_is_jump(res_is_jump),
    .res_taken(res_taken), .res_target(res_target), .res_npc(res_npc),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
    .mispredict(mispredict), .jumping(jumping), .correct_pc(correct_pc),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: the BTB as plain arrays of integers, counter as 0..3
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  longint      m_branches;
  longint      m_mis;

  function automatic void model_reset();
    for (int i = 0; i < int'(ENTRIES); i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_target[i] = 32'h0; m_ctr[i] = 1;
    end
    m_branches = 0;
    m_mis = 0;
  endfunction

  function automatic int unsigned idx_of(logic [31:0] a);
    return (a >> 2) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(logic [31:0] a);
    return a >> (IDX_W + 2);
  endfunction

  function automatic bit model_pred(logic [31:0] a);
    int unsigned i = idx_of(a);
    return m_valid[i] && (m_tag[i] == tag_of(a)) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] model_target(logic [31:0] a);
    return model_pred(a) ? m_target[idx_of(a)] : 32'h0;
  endfunction

  function automatic bit exp_mis();
    return res_valid && res_is_branch &&
           ((res_taken != res_pred_taken) || (res_taken && (res_target != res_pred_target)));
  endfunction

  function automatic logic [31:0] exp_cpc();
    return (res_is_jump || res_taken) ? res_target : res_npc;
  endfunction

  // Applies the training rules to the model for the inputs present at this edge
  function automatic void model_update();
    int unsigned i;
    bit hit;
    if (!(res_valid && res_en && res_is_branch)) return;
    i = idx_of(res_pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(res_pc));
    if (hit) begin
      if (res_taken) begin
        m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
        m_target[i] = res_target;
      end else begin
        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (res_taken) begin
      m_valid[i] = 1'b1; m_tag[i] = tag_of(res_pc); m_target[i] = res_target; m_ctr[i] = 2;
    end
    if (m_branches < 64'h0FFFF_FFFF) m_branches++;
    if (exp_mis() && (m_mis < 64'h0FFFF_FFFF)) m_mis++;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_res(input bit v, input bit en, input bit br, input bit jmp, input bit tk,
                         input logic [31:0] rpc, input logic [31:0] tgt,
                         input bit ptk, input logic [31:0] ptgt);
    res_valid = v; res_en = en; res_is_branch = br; res_is_jump = jmp; res_taken = tk;
    res_pc = rpc; res_target = tgt; res_npc = rpc + 32'd4;
    res_pred_taken = ptk; res_pred_target = ptgt;
  endtask

  task automatic idle();
    set_res(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
  endtask

  // One clock: model follows the edge, bench returns on the next falling edge
  task automatic tick();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
  endtask

  task automatic expect_pred(input string name, input logic [31:0] a, input bit tk, input logic [31:0] tgt);
    pc = a;
    #1;
    check({name, "_pred_taken"}, 32'(pred_taken), 32'(tk));
    check({name, "_pred_target"}, pred_target, tgt);
  endtask

  task automatic expect_counts(input string name, input logic [31:0] b, input logic [31:0] m);
    check({name, "_branch_count"}, branch_count, b);
    check({name, "_mispredict_count"}, mispredict_count, m);
  endtask

  typedef struct {
    bit          v, br, jmp, tk, ptk;
    logic [31:0] tgt, rpc, ptgt;
    bit          e_mis, e_jmp;
    logic [31:0] e_cpc;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [31:0] rand_pc();
    return ((32'($urandom_range(0, 2)) + 32'd1) << 6) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  initial begin
    model_reset();
    nRST = 1'b0;
    pc = 32'h0;
    idle();
    // Resolve-side vectors, res_en=0 so the table never moves
    vecs[0] = '{1,1,0,1,1, 32'h1000, 32'h20, 32'h1000, 0,0, 32'h1000};
    vecs[1] = '{1,1,0,1,1, 32'h1000, 32'h20, 32'h2000, 1,0, 32'h1000};
    vecs[2] = '{1,1,0,0,0, 32'h1000, 32'h20, 32'h2000, 0,0, 32'h24};
    vecs[3] = '{1,1,0,0,1, 32'h1000, 32'h20, 32'h1000, 1,0, 32'h24};
    vecs[4] = '{0,1,0,1,0, 32'h1000, 32'h20, 32'h0,    0,0, 32'h1000};
    vecs[5] = '{1,0,1,0,0, 32'h3000, 32'h20, 32'h0,    0,1, 32'h3000};
    vecs[6] = '{0,0,1,0,0, 32'h3000, 32'h20, 32'h0,    0,0, 32'h3000};
    vecs[7] = '{1,1,1,1,0, 32'h1000, 32'h20, 32'h0,    1,1, 32'h1000};

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    expect_pred("reset", 32'h40, 0, 32'h0);
    expect_counts("reset", 32'h0, 32'h0);
    nRST = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 8; i++) begin
      set_res(vecs[i].v, 0, vecs[i].br, vecs[i].jmp, vecs[i].tk, vecs[i].rpc,
              vecs[i].tgt, vecs[i].ptk, vecs[i].ptgt);
      #1;
      check($sformatf("vec%0d_mispredict", i), 32'(mispredict), 32'(vecs[i].e_mis));
      check($sformatf("vec%0d_jumping", i), 32'(jumping), 32'(vecs[i].e_jmp));
      check($sformatf("vec%0d_correct_pc", i), correct_pc, vecs[i].e_cpc);
      tick();
    end
    expect_counts("vec_no_update", 32'h0, 32'h0);

    // First taken branch allocates the entry
    set_res(1, 1, 1, 0, 1, 32'h40, 32'h100, 0, 32'h0);
    #1;
    check("alloc_mispredict", 32'(mispredict), 32'h1);
    check("alloc_correct_pc", correct_pc, 32'h100);
    tick();
    idle();
    expect_pred("alloc", 32'h40, 1, 32'h100);
    expect_counts("alloc", 32'd1, 32'd1);

    // Two not-taken resolves walk the counter down to strongly not-taken
    @(negedge CLK);
    set_res(1, 1, 1, 0, 0, 32'h40, 32'h100, 1, 32'h100);
    #1;
    check("nt1_mispredict", 32'(mispredict), 32'h1);
    check("nt1_correct_pc", correct_pc, 32'h44);
    tick();
    set_res(1, 1, 1, 0, 0, 32'h40, 32'h100, 0, 32'h0);
    #1;
    check("nt2_mispredict", 32'(mispredict), 32'h0);
    tick();
    idle();
    expect_pred("nt2", 32'h40, 0, 32'h0);
    @(negedge CLK);
    set_res(1, 1, 1, 0, 1, 32'h40, 32'h100, 0, 32'h0);
    tick();
    idle();
    expect_pred("weak_nt", 32'h40, 0, 32'h0);
    expect_counts("after_train", 32'd4, 32'd3);

    // Alias at the same index with a different tag replaces the entry
    @(negedge CLK);
    set_res(1, 1, 1, 0, 1, 32'h440, 32'h500, 0, 32'h0);
    tick();
    idle();
    expect_pred("alias_old", 32'h40, 0, 32'h0);
    expect_pred("alias_new", 32'h440, 1, 32'h500);

    // Jump: flagged for the hazard unit, never trains or counts
    @(negedge CLK);
    set_res(1, 1, 0, 1, 0, 32'h300, 32'h200, 0, 32'h0);
    #1;
    check("jump_jumping", 32'(jumping), 32'h1);
    check("jump_mispredict", 32'(mispredict), 32'h0);
    check("jump_correct_pc", correct_pc, 32'h200);
    tick();
    idle();
    expect_counts("jump", 32'd5, 32'd4);
    expect_pred("jump_table", 32'h300, 0, 32'h0);

    // Stalled branch held for several cycles must not count or train
    @(negedge CLK);
    set_res(1, 0, 1, 0, 1, 32'h80, 32'h900, 0, 32'h0);
    repeat (5) tick();
    idle();
    expect_counts("stall", 32'd5, 32'd4);
    expect_pred("stall", 32'h80, 0, 32'h0);

    // Correct direction, wrong target on a saturated entry
    @(negedge CLK);
    set_res(1, 1, 1, 0, 1, 32'h80, 32'h100, 0, 32'h0);
    tick();
    set_res(1, 1, 1, 0, 1, 32'h80, 32'h100, 1, 32'h100);
    tick();
    set_res(1, 1, 1, 0, 1, 32'h80, 32'h180, 1, 32'h100);
    #1;
    check("tgt_mispredict", 32'(mispredict), 32'h1);
    check("tgt_correct_pc", correct_pc, 32'h180);
    tick();
    idle();
    expect_pred("tgt_update", 32'h80, 1, 32'h180);
    expect_counts("tgt_update", 32'd8, 32'd6);

    // Asynchronous reset in the middle of the high phase
    set_res(1, 1, 1, 0, 1, 32'h80, 32'h180, 1, 32'h180);
    @(posedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    check("async_pred_taken", 32'(pred_taken), 32'h0);
    check("async_pred_target", pred_target, 32'h0);
    expect_counts("async", 32'h0, 32'h0);
    check("async_correct_pc", correct_pc, 32'h180);
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    idle();
    @(negedge CLK);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int unsigned kind;
      logic [31:0] rpc;
      pc = rand_pc();
      rpc = rand_pc();
      kind = $urandom_range(0, 99);
      if ($urandom_range(0, 9) < 7) begin
        set_res($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 80, kind < 65,
                (kind >= 65) && (kind < 80), 1'($urandom), rpc,
                32'h1000 + (32'($urandom_range(0, 3)) << 6),
                model_pred(rpc), model_target(rpc));
      end else begin
        set_res($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 80, kind < 65,
                (kind >= 65) && (kind < 80), 1'($urandom), rpc,
                32'h1000 + (32'($urandom_range(0, 3)) << 6),
                1'($urandom), 32'h1000 + (32'($urandom_range(0, 3)) << 6));
      end
      #1;
      check("rnd_pred_taken", 32'(pred_taken), 32'(model_pred(pc)));
      check("rnd_pred_target", pred_target, model_target(pc));
      check("rnd_mispredict", 32'(mispredict), 32'(exp_mis()));
      check("rnd_jumping", 32'(jumping), 32'(res_valid && res_is_jump));
      check("rnd_correct_pc", correct_pc, exp_cpc());
      tick();
      expect_counts("rnd", 32'(m_branches), 32'(m_mis));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
